pattern_gen_sdl_top: RTL

Self-contained, parametrised video test-pattern source for the SDL simulation harness. It contains its own raster counters and four selectable patterns: colour bars, checkerboard, gradient and scrolling bars. Pixels are registered, and the mode and animation state change only at frame boundaries. The block sits at the top of the simulation build and drives the SDL pixel interface directly.

---
 rtl/pattern_gen_sdl_top.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/pattern_gen_sdl_top.sv
// ============================================================================
// Module      : pattern_gen_sdl_top
// Description : Parametrised video test-pattern source for the SDL harness:
//               raster counters plus colour bars, checkerboard, gradient and
//               scrolling bars. Optional macro PATTERN_BORDER_EN adds a white
//               one-pixel border around the visible area.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_gen_sdl_top #(
    parameter int H_VISIBLE   = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_VISIBLE   = 480,
    parameter int V_TOTAL     = 525,
    parameter int POS_W       = 10,
    parameter int COLOR_W     = 8,
    parameter int CHECK_LOG2  = 5,
    parameter int SCROLL_STEP = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_mode,
    output logic [POS_W-1:0]   o_sdl_hpos,
    output logic [POS_W-1:0]   o_sdl_vpos,
    output logic               o_sdl_visible,
    output logic [COLOR_W-1:0] o_sdl_r,
    output logic [COLOR_W-1:0] o_sdl_g,
    output logic [COLOR_W-1:0] o_sdl_b,
    output logic               o_frame_start
);

    localparam int                 c_BW     = H_VISIBLE / 8;
    localparam logic [POS_W-1:0]   c_H_LAST = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0]   c_V_LAST = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0]   c_H_VIS  = POS_W'(H_VISIBLE);
    localparam logic [POS_W-1:0]   c_V_VIS  = POS_W'(V_VISIBLE);
    localparam logic [POS_W:0]     c_H_VIS_W = (POS_W+1)'(H_VISIBLE);
    localparam logic [POS_W:0]     c_STEP_W  = (POS_W+1)'(SCROLL_STEP);
    localparam logic [COLOR_W-1:0] c_FULL   = {COLOR_W{1'b1}};

    // Raster and per-frame state
    logic [POS_W-1:0]   r_h;
    logic [POS_W-1:0]   r_v;
    logic [1:0]         r_mode;
    logic [POS_W-1:0]   r_scroll;
    logic [7:0]         r_fcnt;

    // Output pipeline registers
    logic [POS_W-1:0]   r_hpos;
    logic [POS_W-1:0]   r_vpos;
    logic               r_visible;
    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;
    logic               r_fs;

    logic               w_fs;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_visible;
    logic [POS_W:0]     w_scroll_sum;
    logic [POS_W-1:0]   w_scroll_next;
    logic [1:0]         w_mode_cur;
    logic [POS_W-1:0]   w_scroll_cur;
    logic [7:0]         w_fcnt_cur;
    logic [POS_W:0]     w_x3_sum;
    logic [POS_W:0]     w_x3;
    logic [2:0]         w_k0;
    logic [2:0]         w_k3;
    logic [COLOR_W-1:0] w_grad_r;
    logic [COLOR_W-1:0] w_grad_g;
    logic [COLOR_W-1:0] w_grad_b;
    logic [COLOR_W-1:0] w_pr;
    logic [COLOR_W-1:0] w_pg;
    logic [COLOR_W-1:0] w_pb;

    // Bar index from seven threshold comparisons against multiples of c_BW
    function automatic logic [2:0] bar_index(input logic [POS_W:0] x);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 1; i < 8; i++) begin
            k = k + {2'b00, (x >= (POS_W+1)'(c_BW * i))};
        end
        return k;
    endfunction

    assign w_fs      = (r_h == '0) && (r_v == '0);
    assign w_h_last  = (r_h == c_H_LAST);
    assign w_v_last  = (r_v == c_V_LAST);
    assign w_visible = (r_h < c_H_VIS) && (r_v < c_V_VIS);

    assign w_scroll_sum  = {1'b0, r_scroll} + c_STEP_W;
    assign w_scroll_next = (w_scroll_sum >= c_H_VIS_W) ? POS_W'(w_scroll_sum - c_H_VIS_W)
                                                       : POS_W'(w_scroll_sum);

    // The frame-start pixel itself must already use the freshly latched state
    assign w_mode_cur   = w_fs ? i_mode        : r_mode;
    assign w_scroll_cur = w_fs ? w_scroll_next : r_scroll;
    assign w_fcnt_cur   = w_fs ? (r_fcnt + 8'd1) : r_fcnt;

    assign w_x3_sum = {1'b0, r_h} + {1'b0, w_scroll_cur};
    assign w_x3     = (w_x3_sum >= c_H_VIS_W) ? (w_x3_sum - c_H_VIS_W) : w_x3_sum;
    assign w_k0     = bar_index({1'b0, r_h});
    assign w_k3     = bar_index(w_x3);

    generate
        if (COLOR_W <= POS_W) begin : g_grad_trunc
            assign w_grad_r = r_h[COLOR_W-1:0];
            assign w_grad_g = r_v[COLOR_W-1:0];
        end else begin : g_grad_ext
            assign w_grad_r = {{(COLOR_W-POS_W){1'b0}}, r_h};
            assign w_grad_g = {{(COLOR_W-POS_W){1'b0}}, r_v};
        end
        if (COLOR_W <= 8) begin : g_fcnt_trunc
            assign w_grad_b = w_fcnt_cur[COLOR_W-1:0];
        end else begin : g_fcnt_ext
            assign w_grad_b = {{(COLOR_W-8){1'b0}}, w_fcnt_cur};
        end
    endgenerate

    always_comb begin
        w_pr = '0;
        w_pg = '0;
        w_pb = '0;
        if (w_visible) begin
            case (w_mode_cur)
                2'd0: begin
                    w_pr = w_k0[2] ? c_FULL : '0;
                    w_pg = w_k0[1] ? c_FULL : '0;
                    w_pb = w_k0[0] ? c_FULL : '0;
                end
                2'd1: begin
                    if (r_h[CHECK_LOG2] ^ r_v[CHECK_LOG2]) begin
                        w_pr = c_FULL;
                        w_pg = c_FULL;
                        w_pb = c_FULL;
                    end
                end
                2'd2: begin
                    w_pr = w_grad_r;
                    w_pg = w_grad_g;
                    w_pb = w_grad_b;
                end
                default: begin
                    w_pr = w_k3[2] ? c_FULL : '0;
                    w_pg = w_k3[1] ? c_FULL : '0;
                    w_pb = w_k3[0] ? c_FULL : '0;
                end
            endcase
`ifdef PATTERN_BORDER_EN
            if ((r_h == '0) || (r_h == c_H_VIS - POS_W'(1)) ||
                (r_v == '0) || (r_v == c_V_VIS - POS_W'(1))) begin
                w_pr = c_FULL;
                w_pg = c_FULL;
                w_pb = c_FULL;
            end
`else
            w_pr = w_pr;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h      <= '0;
            r_v      <= '0;
            r_mode   <= 2'd0;
            r_scroll <= '0;
            r_fcnt   <= 8'd0;
        end else begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + POS_W'(1);
            end else begin
                r_h <= r_h + POS_W'(1);
            end
            if (w_fs) begin
                r_mode   <= i_mode;
                r_scroll <= w_scroll_next;
                r_fcnt   <= r_fcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hpos    <= '0;
            r_vpos    <= '0;
            r_visible <= 1'b0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
            r_fs      <= 1'b0;
        end else begin
            r_hpos    <= r_h;
            r_vpos    <= r_v;
            r_visible <= w_visible;
            r_r       <= w_pr;
            r_g       <= w_pg;
            r_b       <= w_pb;
            r_fs      <= w_fs;
        end
    end

    assign o_sdl_hpos    = r_hpos;
    assign o_sdl_vpos    = r_vpos;
    assign o_sdl_visible = r_visible;
    assign o_sdl_r       = r_r;
    assign o_sdl_g       = r_g;
    assign o_sdl_b       = r_b;
    assign o_frame_start = r_fs;

endmodule

`default_nettype wire
